// File: rtl/iddmm_wb_split.sv
// IDDMM word write-back stage: splits each 2K-bit adder result into a RAM word and an upstream high part.
// Optional data-integrity checks on the discarded low word and the round-top bits: define IDDMM_WB_CHECK_EN.
module iddmm_wb_split #(
  parameter int K      = 256,
  parameter int N      = 16,
  parameter int ADDR_W = $clog2(N)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic              res_valid,
  input  logic [ADDR_W:0]   res_j,
  input  logic [2*K-1:0]    res_data,
  output logic              wr_en,
  output logic [ADDR_W-1:0] wr_addr,
  output logic [K-1:0]      wr_data,
  output logic [K-1:0]      hi_word,
  output logic              top_carry,
  output logic              round_done,
  output logic              done,
  output logic              busy,
  output logic              seq_err
);

  typedef enum logic [1:0] {IDLE, RUN, LAST} state_t;

  localparam logic [ADDR_W:0] J_N    = (ADDR_W+1)'(N);
  localparam logic [ADDR_W:0] I_LAST = (ADDR_W+1)'(N-1);

  state_t          state;
  logic [ADDR_W:0] i_cnt;
  logic [ADDR_W:0] exp_j;
  logic [ADDR_W:0] j_m1;
  logic            j_is_0;
  logic            j_is_n;
  logic            j_mid;
  logic            data_err;

  assign j_is_0 = (res_j == '0);
  assign j_is_n = (res_j == J_N);
  assign j_mid  = !j_is_0 && (res_j < J_N);
  // Result words land one address below their index (division by 2^K).
  assign j_m1   = res_j - 1'b1;

  always_comb begin
    data_err = 1'b0;
`ifdef IDDMM_WB_CHECK_EN
    if (j_is_0 && (res_data[K-1:0] != '0))
      data_err = 1'b1;
    if (j_is_n && (res_data[2*K-1:K+1] != '0))
      data_err = 1'b1;
`endif
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= IDLE;
      i_cnt      <= '0;
      exp_j      <= '0;
      wr_en      <= 1'b0;
      wr_addr    <= '0;
      wr_data    <= '0;
      hi_word    <= '0;
      top_carry  <= 1'b0;
      round_done <= 1'b0;
      done       <= 1'b0;
      busy       <= 1'b0;
      seq_err    <= 1'b0;
    end else begin
      wr_en      <= 1'b0;
      round_done <= 1'b0;
      done       <= 1'b0;

      if (state == RUN && res_valid) begin
        if ((res_j != exp_j) || data_err)
          seq_err <= 1'b1;
        exp_j   <= (exp_j == J_N) ? '0 : exp_j + 1'b1;
        hi_word <= res_data[2*K-1:K];
        if (j_mid || j_is_n) begin
          wr_en   <= 1'b1;
          wr_addr <= j_m1[ADDR_W-1:0];
          wr_data <= res_data[K-1:0];
        end
        if (j_is_n) begin
          top_carry  <= res_data[K];
          round_done <= 1'b1;
          i_cnt      <= i_cnt + 1'b1;
          if (i_cnt == I_LAST)
            state <= LAST;
        end
      end

      // A restart wins over both the in-flight beat's bookkeeping and completion.
      if (start) begin
        state   <= RUN;
        i_cnt   <= '0;
        exp_j   <= '0;
        seq_err <= 1'b0;
        busy    <= 1'b1;
      end else if (state == LAST) begin
        done  <= 1'b1;
        busy  <= 1'b0;
        state <= IDLE;
      end
    end
  end

endmodule
